// File: rtl/readout_pkg.sv
// Shared types and constants for the readout window featurizer.
// Input word field positions and the feature width helper live here.
package readout_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ACCUM,
    EMIT,
    WAIT_PRED,
    STORE
  } state_t;

  localparam int I_MSB = 31;
  localparam int I_LSB = 18;
  localparam int Q_MSB = 17;
  localparam int Q_LSB = 4;

  function automatic int calc_feat_w(
    input int iq_in,
    input int shift_m,
    input int seg,
    input int shift_n
  );
    return iq_in - shift_m + $clog2(seg) - shift_n;
  endfunction

endpackage

// File: rtl/window_accumulator.sv
// Bank of signed I/Q running sums, one pair per window.
// Sums are packed as {q[w], i[w]} pairs, window 0 in the low bits.
module window_accumulator #(
  parameter int NUM_WINDOWS = 2,
  parameter int IQ_W        = 5,
  parameter int ACC_W       = 7,
  parameter int SHIFT_N     = 0,
  parameter int WIN_W       = 1,
  parameter int FEAT_W      = ACC_W - SHIFT_N
) (
  input  logic                              ap_clk,
  input  logic                              rst,
  input  logic                              clr,
  input  logic                              en,
  input  logic [WIN_W-1:0]                  win,
  input  logic [IQ_W-1:0]                   s_i,
  input  logic [IQ_W-1:0]                   s_q,
  output logic [2*NUM_WINDOWS*FEAT_W-1:0]   feats
);

  logic signed [ACC_W-1:0] acc_i [NUM_WINDOWS];
  logic signed [ACC_W-1:0] acc_q [NUM_WINDOWS];
  logic signed [ACC_W-1:0] ext_i;
  logic signed [ACC_W-1:0] ext_q;

  assign ext_i = {{(ACC_W-IQ_W){s_i[IQ_W-1]}}, s_i};
  assign ext_q = {{(ACC_W-IQ_W){s_q[IQ_W-1]}}, s_q};

  // Clear all windows at shot start, otherwise add into the active window.
  always_ff @(posedge ap_clk or posedge rst) begin
    if (rst) begin
      for (int w = 0; w < NUM_WINDOWS; w++) begin
        acc_i[w] <= '0;
        acc_q[w] <= '0;
      end
    end else if (clr) begin
      for (int w = 0; w < NUM_WINDOWS; w++) begin
        acc_i[w] <= '0;
        acc_q[w] <= '0;
      end
    end else if (en) begin
      acc_i[win] <= acc_i[win] + ext_i;
      acc_q[win] <= acc_q[win] + ext_q;
    end
  end

  // Post-shift and pack the sums into the feature vector.
  always_comb begin
    feats = '0;
    for (int w = 0; w < NUM_WINDOWS; w++) begin
      feats[(2*w)*FEAT_W +: FEAT_W]   = FEAT_W'(acc_i[w] >>> SHIFT_N);
      feats[(2*w+1)*FEAT_W +: FEAT_W] = FEAT_W'(acc_q[w] >>> SHIFT_N);
    end
  end

endmodule

// File: rtl/readout_window_featurizer.sv
// Streaming I/Q window featurizer with classifier handoff.
// Writes each prediction (or all-ones on timeout) to a wrapping BRAM.
module readout_window_featurizer
  import readout_pkg::*;
#(
  parameter int NUM_WINDOWS    = 2,
  parameter int WINDOW_SIZE    = 400,
  parameter int DATA_WIDTH     = 32,
  parameter int IQ_WIDTH_IN    = 14,
  parameter int SHIFT_M        = 9,
  parameter int SHIFT_N        = 0,
  parameter int PRED_BITS      = 2,
  parameter int BRAM_ADDR_BITS = 14,
  parameter int PRED_TIMEOUT   = 64,
  localparam int SEG     = WINDOW_SIZE / NUM_WINDOWS,
  localparam int IQ_W    = IQ_WIDTH_IN - SHIFT_M,
  localparam int ACC_W   = IQ_W + $clog2(SEG),
  localparam int FEAT_W  =
    calc_feat_w(IQ_WIDTH_IN, SHIFT_M, SEG, SHIFT_N),
  localparam int FEATS_W = 2 * NUM_WINDOWS * FEAT_W
) (
  input  logic                      ap_clk,
  input  logic                      rst,
  input  logic                      trigger,
  input  logic [DATA_WIDTH-1:0]     in_TDATA,
  input  logic                      in_TVALID,
  output logic [FEATS_W-1:0]        feat_TDATA,
  output logic                      feat_TVALID,
  input  logic                      feat_TREADY,
  input  logic [PRED_BITS-1:0]      pred_TDATA,
  input  logic                      pred_TVALID,
  input  logic                      addr_clear,
  output logic [BRAM_ADDR_BITS-1:0] out_ADDR,
  output logic [PRED_BITS-1:0]      out_DATA,
  output logic                      out_WE,
  output logic                      busy,
  output logic [15:0]               drop_cnt,
  output logic                      timeout_err
);

  localparam int WIN_W = (NUM_WINDOWS > 1) ? $clog2(NUM_WINDOWS) : 1;
  localparam int SEG_W = (SEG > 1) ? $clog2(SEG) : 1;
  localparam int TOT_W = $clog2(WINDOW_SIZE + 1);
  localparam int TMO_W = $clog2(PRED_TIMEOUT + 1);

  state_t state;
  state_t state_nx;

  logic [SEG_W-1:0] seg_cnt;
  logic [WIN_W-1:0] win;
  logic [TOT_W-1:0] tot_cnt;
  logic [TMO_W-1:0] tmo_cnt;

  logic start;
  logic smp;
  logic last;
  logic tmo_hit;
  logic unused_bits;

  assign unused_bits = &{1'b0, in_TDATA};

  assign start   = (state == IDLE) && trigger;
  assign smp     = (state == ACCUM) && in_TVALID;
  assign last    = smp && (tot_cnt == TOT_W'(WINDOW_SIZE - 1));
  assign tmo_hit = (state == WAIT_PRED) && !pred_TVALID &&
                   (tmo_cnt == TMO_W'(PRED_TIMEOUT - 1));

  window_accumulator #(
    .NUM_WINDOWS (NUM_WINDOWS),
    .IQ_W        (IQ_W),
    .ACC_W       (ACC_W),
    .SHIFT_N     (SHIFT_N),
    .WIN_W       (WIN_W),
    .FEAT_W      (FEAT_W)
  ) u_acc (
    .ap_clk (ap_clk),
    .rst    (rst),
    .clr    (start),
    .en     (smp),
    .win    (win),
    .s_i    (in_TDATA[I_MSB:I_LSB+SHIFT_M]),
    .s_q    (in_TDATA[Q_MSB:Q_LSB+SHIFT_M]),
    .feats  (feat_TDATA)
  );

  // State register.
  always_ff @(posedge ap_clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (trigger) state_nx = ACCUM;
      ACCUM:     if (last) state_nx = EMIT;
      EMIT:      if (feat_TREADY) state_nx = WAIT_PRED;
      WAIT_PRED: if (pred_TVALID || tmo_hit) state_nx = STORE;
      STORE:     state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    feat_TVALID = (state == EMIT);
    out_WE      = (state == STORE);
    busy        = (state != IDLE);
  end

  // Sample, window and intra-window counters.
  always_ff @(posedge ap_clk or posedge rst) begin
    if (rst) begin
      seg_cnt <= '0;
      win     <= '0;
      tot_cnt <= '0;
    end else if (start) begin
      seg_cnt <= '0;
      win     <= '0;
      tot_cnt <= '0;
    end else if (smp) begin
      tot_cnt <= tot_cnt + 1'b1;
      if (seg_cnt == SEG_W'(SEG - 1)) begin
        seg_cnt <= '0;
        win     <= win + 1'b1;
      end else begin
        seg_cnt <= seg_cnt + 1'b1;
      end
    end
  end

  // Prediction wait timer, restarts on every WAIT_PRED entry.
  always_ff @(posedge ap_clk or posedge rst) begin
    if (rst)                     tmo_cnt <= '0;
    else if (state != WAIT_PRED) tmo_cnt <= '0;
    else                         tmo_cnt <= tmo_cnt + 1'b1;
  end

  // Latch the prediction, or all-ones if the classifier never answers.
  always_ff @(posedge ap_clk or posedge rst) begin
    if (rst) begin
      out_DATA    <= '0;
      timeout_err <= 1'b0;
    end else if (state == WAIT_PRED) begin
      if (pred_TVALID) begin
        out_DATA <= pred_TDATA;
      end else if (tmo_hit) begin
        out_DATA    <= '1;
        timeout_err <= 1'b1;
      end
    end
  end

  // Write address: advance after each store, clearable only when idle.
  always_ff @(posedge ap_clk or posedge rst) begin
    if (rst)                           out_ADDR <= '0;
    else if (state == STORE)           out_ADDR <= out_ADDR + 1'b1;
    else if (state == IDLE && addr_clear) out_ADDR <= '0;
  end

  // Count triggers that arrive while a shot is in flight.
  always_ff @(posedge ap_clk or posedge rst) begin
    if (rst) drop_cnt <= '0;
    else if (trigger && state != IDLE && drop_cnt != 16'hFFFF)
      drop_cnt <= drop_cnt + 1'b1;
  end

endmodule
